// File: rtl/sec_monitor_pkg.sv
// Shared types and helpers for the tainted-control-flow alert monitor.
// Provides mode encodings, the log entry layout and a saturating add.
package sec_monitor_pkg;

   typedef enum logic [1:0] {
      SEC_MODE_OFF     = 2'd0,
      SEC_MODE_LOG     = 2'd1,
      SEC_MODE_ENFORCE = 2'd2,
      SEC_MODE_ENF_ALT = 2'd3
   } sec_mode_e;

   // Entry fields are sized for the largest supported configuration;
   // the top zero-extends into them and slices back out on read.
   localparam int SEC_UNIT_W = 3;
   localparam int SEC_ROB_W  = 16;
   localparam int SEC_YROT_W = 16;

   typedef struct packed {
      logic [SEC_UNIT_W-1:0] unit;
      logic [SEC_ROB_W-1:0]  rob_idx;
      logic [SEC_YROT_W-1:0] yrot;
      logic                  multi;
   } sec_log_entry_t;

   function automatic logic [31:0] sec_sat_add(
      input logic [31:0] a,
      input logic [31:0] b,
      input logic [31:0] max
   );
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s > {1'b0, max}) return max;
      return s[31:0];
   endfunction

endpackage

// File: rtl/sec_log_fifo.sv
// Synchronous FIFO for violation log entries with clear.
// Ports: clock, reset (sync, active-low), clear, push, pop, wr_data,
//        rd_data (zero when empty), full, empty.
module sec_log_fifo
   import sec_monitor_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clear,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wr_data,
   output logic [W-1:0] rd_data,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]  r_wr;
   logic [AW:0]  r_rd;
   logic [W-1:0] r_mem [DEPTH];
   logic         w_pop;
   logic         w_push;

   // Extra pointer MSB separates full from empty at equal addresses.
   assign empty = (r_wr == r_rd);
   assign full  = (r_wr[AW] != r_rd[AW]) &&
                  (r_wr[AW-1:0] == r_rd[AW-1:0]);

   // A pop frees the slot a same-cycle push needs when full.
   assign w_pop  = pop & ~empty;
   assign w_push = push & (~full | w_pop);

   assign rd_data = empty ? '0 : r_mem[r_rd[AW-1:0]];

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_wr <= '0;
         r_rd <= '0;
      end else if (clear) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + ONE;
         if (w_pop)  r_rd <= r_rd + ONE;
      end
   end

   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/sec_alert_monitor.sv
// Tainted branch/JAL/JALR monitor: per-unit abort alerts, violation log
// FIFO and saturating violation/drop counters.
// Ports: clock, reset, mode, kill, unit_* request buses (in);
//        alert_*/abort_* (out); log_* handshake + log_clear; viol/drop cnt.
module sec_alert_monitor
   import sec_monitor_pkg::*;
#(
   parameter int NUM_UNITS = 2,
   parameter int ROB_IDX_W = 6,
   parameter int YROT_W    = 6,
   parameter int LOG_DEPTH = 4,
   parameter int CNT_W     = 16,
   localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [1:0]                    mode,
   input  logic                          kill,
   input  logic [NUM_UNITS-1:0]          unit_valid,
   input  logic [NUM_UNITS-1:0]          unit_taint,
   input  logic [NUM_UNITS-1:0]          unit_is_br,
   input  logic [NUM_UNITS-1:0]          unit_is_jal,
   input  logic [NUM_UNITS-1:0]          unit_is_jalr,
   input  logic [NUM_UNITS*ROB_IDX_W-1:0] unit_rob_idx,
   input  logic [NUM_UNITS*YROT_W-1:0]   unit_yrot,
   output logic                          alert_valid,
   output logic [NUM_UNITS-1:0]          alert_mask,
   output logic [NUM_UNITS*ROB_IDX_W-1:0] abort_rob_idx,
   output logic [NUM_UNITS*YROT_W-1:0]   abort_yrot,
   output logic                          log_valid,
   input  logic                          log_ready,
   output logic [UW-1:0]                 log_unit,
   output logic [ROB_IDX_W-1:0]          log_rob_idx,
   output logic [YROT_W-1:0]             log_yrot,
   output logic                          log_multi,
   input  logic                          log_clear,
   output logic [CNT_W-1:0]              viol_cnt,
   output logic [CNT_W-1:0]              drop_cnt
);

   localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

   logic [NUM_UNITS-1:0]           w_hit;
   logic                           w_any;
   logic                           w_enf;
   logic [3:0]                     w_cnt;
   logic [3:0]                     w_drop_inc;
   logic                           w_full;
   logic                           w_empty;
   logic                           w_push_ok;
   sec_log_entry_t                 w_entry;
   sec_log_entry_t                 w_head;

   logic                           r_alert;
   logic [NUM_UNITS-1:0]           r_mask;
   logic [NUM_UNITS*ROB_IDX_W-1:0] r_rob;
   logic [NUM_UNITS*YROT_W-1:0]    r_yrot;
   logic [CNT_W-1:0]               r_viol;
   logic [CNT_W-1:0]               r_drop;

   assign w_enf = mode[1];
   assign w_hit = unit_valid & unit_taint &
                  (unit_is_br | unit_is_jal | unit_is_jalr) &
                  {NUM_UNITS{~kill & (mode != SEC_MODE_OFF)}};
   assign w_any = |w_hit;

   // Descending scan leaves the lowest hitting unit in the entry.
   always_comb begin
      w_entry = '0;
      w_cnt   = '0;
      for (int i = NUM_UNITS - 1; i >= 0; i--) begin
         if (w_hit[i]) begin
            w_entry.unit = SEC_UNIT_W'(i);
            w_entry.rob_idx = '0;
            w_entry.rob_idx[ROB_IDX_W-1:0] =
               unit_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
            w_entry.yrot = '0;
            w_entry.yrot[YROT_W-1:0] = unit_yrot[i*YROT_W +: YROT_W];
         end
      end
      for (int i = 0; i < NUM_UNITS; i++)
         w_cnt = w_cnt + {3'b000, w_hit[i]};
      w_entry.multi = (w_cnt > 4'd1);
   end

   assign w_push_ok  = w_any & (~w_full | (log_ready & ~w_empty));
   assign w_drop_inc = !w_any   ? 4'd0 :
                       w_push_ok ? w_cnt - 4'd1 : w_cnt;

   sec_log_fifo #(
      .DEPTH (LOG_DEPTH),
      .W     ($bits(sec_log_entry_t))
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .clear   (log_clear),
      .push    (w_any),
      .pop     (log_ready),
      .wr_data (w_entry),
      .rd_data (w_head),
      .full    (w_full),
      .empty   (w_empty)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_alert <= 1'b0;
         r_mask  <= '0;
         r_rob   <= '0;
         r_yrot  <= '0;
      end else begin
         r_alert <= w_any & w_enf;
         r_mask  <= w_hit & {NUM_UNITS{w_enf}};
         for (int i = 0; i < NUM_UNITS; i++) begin
            r_rob[i*ROB_IDX_W +: ROB_IDX_W] <= (w_hit[i] & w_enf) ?
               unit_rob_idx[i*ROB_IDX_W +: ROB_IDX_W] : '0;
            r_yrot[i*YROT_W +: YROT_W] <= (w_hit[i] & w_enf) ?
               unit_yrot[i*YROT_W +: YROT_W] : '0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset || log_clear) begin
         r_viol <= '0;
         r_drop <= '0;
      end else begin
         r_viol <= CNT_W'(sec_sat_add(32'(r_viol), 32'(w_cnt), CNT_MAX));
         r_drop <= CNT_W'(sec_sat_add(32'(r_drop), 32'(w_drop_inc),
                                      CNT_MAX));
      end
   end

   assign alert_valid   = r_alert;
   assign alert_mask    = r_mask;
   assign abort_rob_idx = r_rob;
   assign abort_yrot    = r_yrot;
   assign log_valid     = ~w_empty;
   assign log_unit      = w_head.unit[UW-1:0];
   assign log_rob_idx   = w_head.rob_idx[ROB_IDX_W-1:0];
   assign log_yrot      = w_head.yrot[YROT_W-1:0];
   assign log_multi     = w_head.multi;
   assign viol_cnt      = r_viol;
   assign drop_cnt      = r_drop;

endmodule

// File: tb/tb_sec_alert_monitor.sv
// Directed self-checking bench for sec_alert_monitor.
// A second instance with CNT_W=4 covers counter saturation.
module tb_sec_alert_monitor;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  mode;
   logic        kill;
   logic [1:0]  unit_valid, unit_taint, unit_is_br, unit_is_jal, unit_is_jalr;
   logic [11:0] unit_rob_idx, unit_yrot;
   logic        log_ready, log_clear;

   logic        alert_valid, log_valid, log_multi;
   logic [1:0]  alert_mask;
   logic [11:0] abort_rob_idx, abort_yrot;
   logic [0:0]  log_unit;
   logic [5:0]  log_rob_idx, log_yrot;
   logic [15:0] viol_cnt, drop_cnt;

   logic        a4_valid, l4_valid, l4_multi;
   logic [1:0]  a4_mask;
   logic [11:0] a4_rob, a4_yrot;
   logic [0:0]  l4_unit;
   logic [5:0]  l4_rob, l4_yrot;
   logic [3:0]  v4_cnt, d4_cnt;

   int tot = 0;
   int pas = 0;

   always #5 clock = ~clock;

   sec_alert_monitor dut (
      .clock(clock), .reset(reset), .mode(mode), .kill(kill),
      .unit_valid(unit_valid), .unit_taint(unit_taint),
      .unit_is_br(unit_is_br), .unit_is_jal(unit_is_jal),
      .unit_is_jalr(unit_is_jalr), .unit_rob_idx(unit_rob_idx),
      .unit_yrot(unit_yrot), .alert_valid(alert_valid),
      .alert_mask(alert_mask), .abort_rob_idx(abort_rob_idx),
      .abort_yrot(abort_yrot), .log_valid(log_valid),
      .log_ready(log_ready), .log_unit(log_unit),
      .log_rob_idx(log_rob_idx), .log_yrot(log_yrot),
      .log_multi(log_multi), .log_clear(log_clear),
      .viol_cnt(viol_cnt), .drop_cnt(drop_cnt)
   );

   sec_alert_monitor #(.CNT_W(4)) dut4 (
      .clock(clock), .reset(reset), .mode(mode), .kill(kill),
      .unit_valid(unit_valid), .unit_taint(unit_taint),
      .unit_is_br(unit_is_br), .unit_is_jal(unit_is_jal),
      .unit_is_jalr(unit_is_jalr), .unit_rob_idx(unit_rob_idx),
      .unit_yrot(unit_yrot), .alert_valid(a4_valid),
      .alert_mask(a4_mask), .abort_rob_idx(a4_rob),
      .abort_yrot(a4_yrot), .log_valid(l4_valid),
      .log_ready(log_ready), .log_unit(l4_unit),
      .log_rob_idx(l4_rob), .log_yrot(l4_yrot),
      .log_multi(l4_multi), .log_clear(log_clear),
      .viol_cnt(v4_cnt), .drop_cnt(d4_cnt)
   );

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic idle;
      kill = 0;
      unit_valid = 0; unit_taint = 0;
      unit_is_br = 0; unit_is_jal = 0; unit_is_jalr = 0;
      unit_rob_idx = 0; unit_yrot = 0;
   endtask

   task automatic set_unit(input int u, input logic v, input logic t,
                           input logic br, input logic jal, input logic jalr,
                           input logic [5:0] rob, input logic [5:0] y);
      unit_valid[u] = v; unit_taint[u] = t;
      unit_is_br[u] = br; unit_is_jal[u] = jal; unit_is_jalr[u] = jalr;
      unit_rob_idx[u*6 +: 6] = rob;
      unit_yrot[u*6 +: 6] = y;
   endtask

   task automatic do_clear;
      log_clear = 1; tick; log_clear = 0;
   endtask

   task automatic test_reset;
      reset = 0; mode = 2; log_ready = 0; log_clear = 0; idle;
      set_unit(0, 1, 1, 1, 0, 0, 6'h3F, 6'h3F);
      tick; tick;
      tot++; if (alert_valid !== 1'b0) $display("FAIL rst_alert got=%0h exp=0", alert_valid); else pas++;
      tot++; if (alert_mask !== 2'b00) $display("FAIL rst_mask got=%0h exp=0", alert_mask); else pas++;
      tot++; if (abort_rob_idx !== 12'h0) $display("FAIL rst_abort_rob got=%0h exp=0", abort_rob_idx); else pas++;
      tot++; if (log_valid !== 1'b0) $display("FAIL rst_log_valid got=%0h exp=0", log_valid); else pas++;
      tot++; if ({log_unit, log_rob_idx, log_yrot, log_multi} !== 14'h0)
         $display("FAIL rst_log_data got=%0h exp=0", {log_unit, log_rob_idx, log_yrot, log_multi}); else pas++;
      tot++; if (viol_cnt !== 16'd0 || drop_cnt !== 16'd0)
         $display("FAIL rst_cnt got=%0d/%0d exp=0/0", viol_cnt, drop_cnt); else pas++;
      idle; reset = 1; tick;
   endtask

   task automatic test_enforce_single;
      do_clear;
      mode = 2;
      set_unit(1, 1, 1, 0, 0, 1, 6'h2A, 6'h05);
      tick; idle;
      tot++; if (alert_valid !== 1'b1) $display("FAIL enf_alert got=%0h exp=1", alert_valid); else pas++;
      tot++; if (alert_mask !== 2'b10) $display("FAIL enf_mask got=%0h exp=2", alert_mask); else pas++;
      tot++; if (abort_rob_idx !== 12'hA80) $display("FAIL enf_abort_rob got=%0h exp=a80", abort_rob_idx); else pas++;
      tot++; if (abort_yrot !== 12'h140) $display("FAIL enf_abort_yrot got=%0h exp=140", abort_yrot); else pas++;
      tot++; if (log_valid !== 1'b1 || log_unit !== 1'b1 || log_rob_idx !== 6'h2A || log_yrot !== 6'h05 || log_multi !== 1'b0)
         $display("FAIL enf_log got=%0h/%0h/%0h/%0h/%0h exp=1/1/2a/5/0", log_valid, log_unit, log_rob_idx, log_yrot, log_multi); else pas++;
      tot++; if (viol_cnt !== 16'd1 || drop_cnt !== 16'd0)
         $display("FAIL enf_cnt got=%0d/%0d exp=1/0", viol_cnt, drop_cnt); else pas++;
      tick;
      tot++; if (alert_valid !== 1'b0 || alert_mask !== 2'b00)
         $display("FAIL enf_pulse got=%0h/%0h exp=0/0", alert_valid, alert_mask); else pas++;
      log_ready = 1; tick; log_ready = 0;
      tot++; if (log_valid !== 1'b0) $display("FAIL enf_pop got=%0h exp=0", log_valid); else pas++;
   endtask

   task automatic test_kill;
      mode = 2;
      set_unit(0, 1, 1, 1, 0, 0, 6'h11, 6'h03);
      set_unit(1, 1, 1, 0, 1, 0, 6'h22, 6'h04);
      kill = 1;
      tick;
      tot++; if (alert_valid !== 1'b0 || log_valid !== 1'b0 || viol_cnt !== 16'd1)
         $display("FAIL kill_supp got=%0h/%0h/%0d exp=0/0/1", alert_valid, log_valid, viol_cnt); else pas++;
      kill = 0;
      tick; idle;
      tot++; if (alert_mask !== 2'b11 || abort_rob_idx !== 12'h891 || abort_yrot !== 12'h103)
         $display("FAIL dual_alert got=%0h/%0h/%0h exp=3/891/103", alert_mask, abort_rob_idx, abort_yrot); else pas++;
      tot++; if (log_unit !== 1'b0 || log_rob_idx !== 6'h11 || log_multi !== 1'b1)
         $display("FAIL dual_log got=%0h/%0h/%0h exp=0/11/1", log_unit, log_rob_idx, log_multi); else pas++;
      tot++; if (viol_cnt !== 16'd3 || drop_cnt !== 16'd1)
         $display("FAIL dual_cnt got=%0d/%0d exp=3/1", viol_cnt, drop_cnt); else pas++;
      log_ready = 1; tick;
      tot++; if (log_valid !== 1'b0) $display("FAIL dual_single_entry got=%0h exp=0", log_valid); else pas++;
      log_ready = 0;
   endtask

   task automatic test_log_mode;
      do_clear;
      tot++; if (viol_cnt !== 16'd0 || drop_cnt !== 16'd0 || log_valid !== 1'b0)
         $display("FAIL clr got=%0d/%0d/%0h exp=0/0/0", viol_cnt, drop_cnt, log_valid); else pas++;
      mode = 1;
      set_unit(0, 1, 1, 1, 0, 0, 6'h07, 6'h01);
      tick;
      tot++; if (alert_valid !== 1'b0 || log_valid !== 1'b1 || log_rob_idx !== 6'h07 || viol_cnt !== 16'd1)
         $display("FAIL logmode got=%0h/%0h/%0h/%0d exp=0/1/7/1", alert_valid, log_valid, log_rob_idx, viol_cnt); else pas++;
      mode = 0; log_ready = 1;
      tick;
      log_ready = 0;
      tot++; if (alert_valid !== 1'b0 || log_valid !== 1'b0 || viol_cnt !== 16'd1)
         $display("FAIL offmode got=%0h/%0h/%0d exp=0/0/1", alert_valid, log_valid, viol_cnt); else pas++;
      idle;
   endtask

   task automatic test_no_response;
      mode = 2;
      set_unit(0, 1, 0, 1, 1, 1, 6'h01, 6'h01);
      set_unit(1, 1, 1, 0, 0, 0, 6'h02, 6'h02);
      tick; idle;
      tot++; if (alert_valid !== 1'b0 || log_valid !== 1'b0 || viol_cnt !== 16'd1)
         $display("FAIL noresp got=%0h/%0h/%0d exp=0/0/1", alert_valid, log_valid, viol_cnt); else pas++;
   endtask

   task automatic test_full;
      do_clear;
      mode = 1; log_ready = 0;
      for (int k = 1; k <= 5; k++) begin
         set_unit(0, 1, 1, 1, 0, 0, 6'(k), 6'h00);
         tick;
      end
      tot++; if (viol_cnt !== 16'd5 || drop_cnt !== 16'd1 || log_rob_idx !== 6'd1)
         $display("FAIL full_fill got=%0d/%0d/%0h exp=5/1/1", viol_cnt, drop_cnt, log_rob_idx); else pas++;
      set_unit(0, 1, 1, 1, 0, 0, 6'd6, 6'h00);
      log_ready = 1;
      tick; idle;
      tot++; if (viol_cnt !== 16'd6 || drop_cnt !== 16'd1 || log_rob_idx !== 6'd2)
         $display("FAIL full_poppush got=%0d/%0d/%0h exp=6/1/2", viol_cnt, drop_cnt, log_rob_idx); else pas++;
      tick;
      tot++; if (log_rob_idx !== 6'd3) $display("FAIL drain1 got=%0h exp=3", log_rob_idx); else pas++;
      tick;
      tot++; if (log_rob_idx !== 6'd4) $display("FAIL drain2 got=%0h exp=4", log_rob_idx); else pas++;
      tick;
      tot++; if (log_valid !== 1'b1 || log_rob_idx !== 6'd6)
         $display("FAIL drain3 got=%0h/%0h exp=1/6", log_valid, log_rob_idx); else pas++;
      tick;
      tot++; if (log_valid !== 1'b0) $display("FAIL drain_empty got=%0h exp=0", log_valid); else pas++;
      tick;
      tot++; if (log_valid !== 1'b0) $display("FAIL pop_on_empty got=%0h exp=0", log_valid); else pas++;
      log_ready = 0;
   endtask

   task automatic test_saturate;
      do_clear;
      mode = 2; log_ready = 0;
      set_unit(0, 1, 1, 1, 0, 0, 6'h01, 6'h01);
      set_unit(1, 1, 1, 1, 0, 0, 6'h02, 6'h02);
      for (int k = 0; k < 7; k++) tick;
      tot++; if (v4_cnt !== 4'd14 || d4_cnt !== 4'd10)
         $display("FAIL sat_pre got=%0d/%0d exp=14/10", v4_cnt, d4_cnt); else pas++;
      tick;
      tot++; if (v4_cnt !== 4'd15 || d4_cnt !== 4'd12)
         $display("FAIL sat_hold got=%0d/%0d exp=15/12", v4_cnt, d4_cnt); else pas++;
      tick;
      tot++; if (v4_cnt !== 4'd15 || d4_cnt !== 4'd14)
         $display("FAIL sat_stay got=%0d/%0d exp=15/14", v4_cnt, d4_cnt); else pas++;
      tot++; if (viol_cnt !== 16'd18) $display("FAIL wide_cnt got=%0d exp=18", viol_cnt); else pas++;
      set_unit(1, 0, 0, 0, 0, 0, 6'h00, 6'h00);
      log_clear = 1;
      tick; log_clear = 0; idle;
      tot++; if (v4_cnt !== 4'd0 || d4_cnt !== 4'd0 || l4_valid !== 1'b0 || log_valid !== 1'b0 || viol_cnt !== 16'd0)
         $display("FAIL clr_prio got=%0d/%0d/%0h/%0h/%0d exp=0/0/0/0/0", v4_cnt, d4_cnt, l4_valid, log_valid, viol_cnt); else pas++;
      tot++; if (alert_valid !== 1'b1 || alert_mask !== 2'b01)
         $display("FAIL clr_keeps_alert got=%0h/%0h exp=1/1", alert_valid, alert_mask); else pas++;
   endtask

   task automatic test_reset_mid;
      mode = 2;
      set_unit(0, 1, 1, 1, 0, 0, 6'h15, 6'h2A);
      set_unit(1, 1, 1, 0, 1, 0, 6'h16, 6'h2B);
      tick; tick;
      reset = 0;
      tick;
      tot++; if (alert_valid !== 1'b0 || alert_mask !== 2'b00 || abort_rob_idx !== 12'h0 || abort_yrot !== 12'h0)
         $display("FAIL midrst_alert got=%0h/%0h/%0h/%0h exp=0/0/0/0", alert_valid, alert_mask, abort_rob_idx, abort_yrot); else pas++;
      tot++; if (log_valid !== 1'b0 || log_rob_idx !== 6'h0 || viol_cnt !== 16'd0 || drop_cnt !== 16'd0)
         $display("FAIL midrst_log got=%0h/%0h/%0d/%0d exp=0/0/0/0", log_valid, log_rob_idx, viol_cnt, drop_cnt); else pas++;
      idle; reset = 1;
      tick;
      tot++; if (log_valid !== 1'b0) $display("FAIL midrst_discard got=%0h exp=0", log_valid); else pas++;
   endtask

   initial begin
      test_reset;
      test_enforce_single;
      test_kill;
      test_log_mode;
      test_no_response;
      test_full;
      test_saturate;
      test_reset_mid;
      $display("%0d/%0d checks passed", pas, tot);
      $finish;
   end

endmodule

// File: doc/sec_alert_monitor.md
# sec_alert_monitor

Parametrised successor to the core's two-unit tainted-control-flow monitor. Watches NUM_UNITS branch-resolving execution units for valid, tainted branch/JAL/JALR uops, raises a registered per-unit abort alert toward the ROB, and records every detected violation in a handshaked log FIFO read by the CSR/debug side. A mode input selects OFF, LOG-only or ENFORCE. Saturating counters track violations and dropped log entries.

## Interface
Parameters:
- NUM_UNITS, 2, number of monitored execution units (1..8)
- ROB_IDX_W, 6, ROB index width
- YROT_W, 6, youngest-root-of-taint field width
- LOG_DEPTH, 4, log FIFO entries (power of two, >=2)
- CNT_W, 16, width of both saturating counters

Ports (unit-indexed buses are flattened, unit i in bits [i*W +: W]):
- clock  in  1  sole clock
- reset  in  1  synchronous, active-low reset
- mode  in  2  0 OFF, 1 LOG, 2 ENFORCE, 3 treated as ENFORCE
- kill  in  1  pipeline flush; suppresses all hits this cycle
- unit_valid  in  NUM_UNITS  request valid per unit
- unit_taint  in  NUM_UNITS  uop taint bit
- unit_is_br / unit_is_jal / unit_is_jalr  in  NUM_UNITS each  control-flow type
- unit_rob_idx  in  NUM_UNITS*ROB_IDX_W  uop ROB index
- unit_yrot  in  NUM_UNITS*YROT_W  uop yrot
- alert_valid  out  1  any unit aborted
- alert_mask  out  NUM_UNITS  per-unit abort
- abort_rob_idx  out  NUM_UNITS*ROB_IDX_W  zero for non-alerting units
- abort_yrot  out  NUM_UNITS*YROT_W  zero for non-alerting units
- log_valid  out  1  log head valid
- log_ready  in  1  consumer pops head
- log_unit  out  clog2(NUM_UNITS) (min 1)  unit id of head entry
- log_rob_idx  out  ROB_IDX_W  head ROB index
- log_yrot  out  YROT_W  head yrot
- log_multi  out  1  head entry's cycle had >1 hit
- log_clear  in  1  empties FIFO, zeroes counters
- viol_cnt  out  CNT_W  violations counted
- drop_cnt  out  CNT_W  violations not logged

## Operation
- hit[i] = unit_valid[i] & unit_taint[i] & (is_br|is_jal|is_jalr)[i] & ~kill & (mode != OFF).
- Alert register: loads hit & {NUM_UNITS{mode>=2}}; rob_idx/yrot fields load the unit's value when alerting, else zero. Reloaded every cycle (one-cycle pulse per hit).
- Log push: when any hit, push one entry: lowest-index hitting unit, its rob_idx/yrot, multi = popcount(hit)>1. Higher-index hits in the same cycle are not logged.
- viol_cnt += popcount(hit), saturating at 2^CNT_W-1.
- drop_cnt += popcount(hit)-1 if pushed, += popcount(hit) if push refused (FIFO full and no pop that cycle); saturating.
- Pop when log_valid & log_ready. Full FIFO with simultaneous pop and push: both occur, count unchanged, no drop. Pop on empty ignored.
- log_clear: FIFO emptied, both counters zeroed; takes priority over push/pop/increments of that cycle. Does not affect alert register.
- kill suppresses only same-cycle hits; an alert already registered still presents.
- Mode change takes effect for hits in the same cycle.

## Timing
- Hit in cycle t -> alert outputs, log entry (log_valid), counter updates visible in t+1. Alert lasts exactly one cycle unless hits repeat.
- Log head is registered; after pop in t, next entry visible in t+1.
- Reset (reset low at a clock edge): all outputs 0, FIFO empty (log_valid=0), counters 0, log data outputs 0. Reset mid-operation discards all FIFO contents.
- Pointer wrap-around at LOG_DEPTH via extra MSB full/empty detection.

## Structure
- Package sec_monitor_pkg: mode encodings (SEC_MODE_OFF/LOG/ENFORCE), log entry struct {unit, rob_idx, yrot, multi}, saturating-add helper function.
- Sub-module sec_log_fifo: synchronous FIFO of log entries with push/pop/clear, full/empty, parametrised depth and entry width.
- Top holds hit detection, priority encoder, popcount, alert register, counters.

## Test plan
- ENFORCE, unit1 valid+taint+is_jalr, rob_idx 0x2A, yrot 0x05 -> next cycle alert_valid=1, mask=2'b10, abort_rob_idx[1]=0x2A, yrot[1]=0x05, unit0 fields 0; log entry unit=1; viol_cnt=1.
- ENFORCE, units 0 and 1 hit same cycle with kill=1 -> no alert, no log, counters unchanged; repeat with kill=0 -> mask=2'b11, one log entry unit=0 multi=1, viol_cnt+=2, drop_cnt+=1.
- LOG mode, unit0 tainted branch -> alert_valid stays 0; log entry present; viol_cnt=1. OFF mode same stimulus -> nothing.
- log_ready=0, 5 single hits with LOG_DEPTH=4 -> 4 entries held, drop_cnt=1; then full FIFO with pop+hit same cycle -> entry count stays 4, drop_cnt unchanged; drain order matches push order.
- Untainted or non-control-flow uops (taint=0, or all type bits 0) -> no response.
- Preload counters near saturation (CNT_W=4, 16 hits) -> viol_cnt holds 15; log_clear -> counters 0, log_valid=0 next cycle; reset low mid-burst -> all outputs 0.
